// File: rtl/x_axis_motor_driver_if.sv
// X-axis motor link: the subsystem side (master) issues the command, duty
// limit and tach clock; the driver side (slave) returns the power-stage
// drive and status.
interface x_axis_motor_driver_if #(
  parameter int PWM_BITS = 8
);
  logic [1:0]          motor_ctrl_signal;
  logic                feedback_clk;
  logic [PWM_BITS-1:0] duty_max;
  logic                motor_pwm;
  logic                motor_enable;
  logic                motor_brake;
  logic [PWM_BITS-1:0] duty;
  logic                feedback_pulse;
  logic                fault;
  logic [1:0]          state;

  modport master (
    output motor_ctrl_signal, feedback_clk, duty_max,
    input  motor_pwm, motor_enable, motor_brake, duty, feedback_pulse, fault, state
  );

  modport slave (
    input  motor_ctrl_signal, feedback_clk, duty_max,
    output motor_pwm, motor_enable, motor_brake, duty, feedback_pulse, fault, state
  );
endinterface

// File: rtl/x_axis_motor_driver.sv
// X-axis spinner motor driver: slew-limited PWM drive, enable/brake lines and
// a tach-clock watchdog that latches a loss-of-rotation fault.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | power stage off, duty 0; brake held if stopped by a brake
// SPINUP | enabled, ramping, waiting for the first tach edge
// RUN    | enabled, duty follows the ramp, watchdog armed
// FAULT  | rotation lost; off, braking, fault latched until coast
module x_axis_motor_driver #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_DIV    = 50000,
  parameter int WDOG_CYCLES = 5000000
) (
  input logic                    clk,
  input logic                    reset,
  x_axis_motor_driver_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPINUP = 2'd1,
    S_RUN    = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_ACCEL = 2'b01;
  localparam logic [1:0] CMD_BRAKE = 2'b10;

  localparam int PR_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [PR_W-1:0]     PR_LAST  = PR_W'(RAMP_DIV - 1);
  localparam logic [WD_W-1:0]     WD_LAST  = WD_W'(WDOG_CYCLES - 1);
  // PWM counter wraps one short of all-ones so a full-scale duty is solid high.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [1:0]          cmd_q;
  logic                fb_s1_q, fb_s2_q, fb_prev_q, fb_pulse_q;
  logic [PR_W-1:0]     presc_q;
  logic [WD_W-1:0]     wd_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  state_t              state_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic                enable_q, brake_q, fault_q, pwm_q;

  logic fb_rise;
  logic active;
  logic ramp_tick;
  logic timeout;

  assign fb_rise   = fb_s2_q & ~fb_prev_q;
  assign active    = (state_q == S_SPINUP) || (state_q == S_RUN);
  assign ramp_tick = active && (presc_q == '0);
  assign timeout   = active && (wd_cnt_q == WD_LAST);

  // Command register: everything downstream acts on the registered command.
  always_ff @(posedge clk) begin
    if (reset) cmd_q <= CMD_COAST;
    else       cmd_q <= bus.motor_ctrl_signal;
  end

  // Tach synchronizer, edge register and one-cycle rising-edge strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_s1_q    <= 1'b0;
      fb_s2_q    <= 1'b0;
      fb_prev_q  <= 1'b0;
      fb_pulse_q <= 1'b0;
    end else begin
      fb_s1_q    <= bus.feedback_clk;
      fb_s2_q    <= fb_s1_q;
      fb_prev_q  <= fb_s2_q;
      fb_pulse_q <= fb_rise;
    end
  end

  // Ramp prescaler: down-counter that ticks at zero and reloads; idle when stopped.
  always_ff @(posedge clk) begin
    if (reset || !active)    presc_q <= '0;
    else if (presc_q == '0)  presc_q <= PR_LAST;
    else                     presc_q <= presc_q - 1'b1;
  end

  // Watchdog: cleared by each tach edge (as the strobe is generated), holds at the limit.
  always_ff @(posedge clk) begin
    if (reset || !active)        wd_cnt_q <= '0;
    else if (fb_rise)            wd_cnt_q <= '0;
    else if (wd_cnt_q != WD_LAST) wd_cnt_q <= wd_cnt_q + 1'b1;
  end

  // PWM carrier counter.
  always_ff @(posedge clk) begin
    if (reset)                    pwm_cnt_q <= '0;
    else if (pwm_cnt_q == PWM_LAST) pwm_cnt_q <= '0;
    else                          pwm_cnt_q <= pwm_cnt_q + 1'b1;
  end

  // One-LSB step toward the commanded target on each ramp tick.
  always_comb begin
    duty_d = duty_q;
    if (ramp_tick) begin
      case (cmd_q)
        CMD_ACCEL: begin
          if (duty_q < bus.duty_max)      duty_d = duty_q + 1'b1;
          else if (duty_q > bus.duty_max) duty_d = duty_q - 1'b1;
        end
        CMD_COAST: begin
          if (duty_q != '0) duty_d = duty_q - 1'b1;
        end
        default: duty_d = duty_q;
      endcase
    end
  end

  // Sequencer with registered drive outputs; brake and timeout force the gate low at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      duty_q   <= '0;
      enable_q <= 1'b0;
      brake_q  <= 1'b0;
      fault_q  <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      pwm_q <= enable_q & (pwm_cnt_q < duty_q);
      case (state_q)
        S_IDLE: begin
          duty_q   <= '0;
          enable_q <= 1'b0;
          if (cmd_q == CMD_ACCEL) begin
            state_q  <= S_SPINUP;
            enable_q <= 1'b1;
            brake_q  <= 1'b0;
          end else if (cmd_q == CMD_COAST) begin
            brake_q <= 1'b0;
          end
        end
        S_SPINUP, S_RUN: begin
          if (cmd_q == CMD_BRAKE) begin
            state_q  <= S_IDLE;
            duty_q   <= '0;
            enable_q <= 1'b0;
            brake_q  <= 1'b1;
            pwm_q    <= 1'b0;
          end else if (timeout) begin
            state_q  <= S_FAULT;
            duty_q   <= '0;
            enable_q <= 1'b0;
            brake_q  <= 1'b1;
            fault_q  <= 1'b1;
            pwm_q    <= 1'b0;
          end else begin
            duty_q <= duty_d;
            if (state_q == S_SPINUP && fb_pulse_q) begin
              state_q <= S_RUN;
            end else if (cmd_q == CMD_COAST && duty_q == '0) begin
              state_q  <= S_IDLE;
              enable_q <= 1'b0;
            end
          end
        end
        S_FAULT: begin
          duty_q   <= '0;
          enable_q <= 1'b0;
          brake_q  <= 1'b1;
          fault_q  <= 1'b1;
          if (cmd_q == CMD_COAST) begin
            state_q <= S_IDLE;
            brake_q <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.motor_pwm      = pwm_q;
  assign bus.motor_enable   = enable_q;
  assign bus.motor_brake    = brake_q;
  assign bus.duty           = duty_q;
  assign bus.feedback_pulse = fb_pulse_q;
  assign bus.fault          = fault_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_x_axis_motor_driver.sv
// Scenario bench for x_axis_motor_driver (PWM_BITS=4, RAMP_DIV=4, WDOG_CYCLES=100).
// Expectations come from closed-form timing rules: ramp position from elapsed
// cycles, tach strobe from the tach waveform three cycles earlier, watchdog
// expiry a fixed distance from the last strobe.
module tb_x_axis_motor_driver;

  logic clk = 1'b0;
  logic reset = 1'b1;

  x_axis_motor_driver_if #(.PWM_BITS(4)) bus ();

  x_axis_motor_driver #(
    .PWM_BITS(4),
    .RAMP_DIV(4),
    .WDOG_CYCLES(100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  int fb_period = 0;
  int fb_phase = 0;
  logic [3:0] hist = '0;
  logic exp_pulse;

  // Advance one clock; inputs were set after the previous edge, outputs are
  // read 1 time unit after this edge. The tach strobe must follow the tach
  // waveform sampled three edges earlier.
  task automatic step();
    @(posedge clk);
    if (reset) hist = '0;
    else       hist = {hist[2:0], bus.feedback_clk};
    #1;
    cyc++;
    exp_pulse = hist[2] & ~hist[3];
    n_checks++;
    if (bus.feedback_pulse !== exp_pulse)
      $display("FAIL fb_pulse cyc=%0d got=%b exp=%b", cyc, bus.feedback_pulse, exp_pulse);
    else n_pass++;
    if (exp_pulse) last_pulse_cyc = cyc;
    if (fb_period > 0) begin
      fb_phase = (fb_phase + 1) % fb_period;
      bus.feedback_clk = (fb_phase < fb_period / 2) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.motor_ctrl_signal = 2'b00;
    fb_period = 0;
    bus.feedback_clk = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.duty_max = 4'($urandom_range(0, 15));
    do_reset();
    n_checks++;
    if ({bus.state, bus.duty, bus.motor_pwm, bus.motor_enable, bus.motor_brake, bus.fault} !== 10'b0)
      $display("FAIL reset_outputs got state=%0d duty=%0d pwm=%b en=%b brk=%b flt=%b exp all 0",
               bus.state, bus.duty, bus.motor_pwm, bus.motor_enable, bus.motor_brake, bus.fault);
    else n_pass++;
  endtask

  // Accelerate from reset with a running tach; after SPINUP entry (k=0),
  // duty(k) = min(dm, (k+3)/4), RUN from k=4 (first strobe at k=3).
  task automatic test_spinup(input int dm, input int period);
    logic [3:0] exp_duty;
    logic [1:0] exp_state;
    int hi_cnt;
    do_reset();
    bus.duty_max = 4'(dm);
    bus.motor_ctrl_signal = 2'b01;
    step();
    n_checks++;
    if (bus.state !== 2'd0) $display("FAIL spin_state_e1 got=%0d exp=0", bus.state);
    else n_pass++;
    step();
    n_checks++;
    if (bus.state !== 2'd1 || bus.motor_enable !== 1'b1 || bus.duty !== 4'd0)
      $display("FAIL spin_entry got state=%0d en=%b duty=%0d exp 1/1/0", bus.state, bus.motor_enable, bus.duty);
    else n_pass++;
    fb_phase = 0;
    fb_period = period;
    bus.feedback_clk = 1'b1;
    hi_cnt = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      exp_duty = ((k + 3) / 4 < dm) ? 4'((k + 3) / 4) : 4'(dm);
      exp_state = (k >= 4) ? 2'd2 : 2'd1;
      n_checks++;
      if (bus.duty !== exp_duty) $display("FAIL spin_duty k=%0d got=%0d exp=%0d", k, bus.duty, exp_duty);
      else n_pass++;
      n_checks++;
      if (bus.state !== exp_state || bus.motor_enable !== 1'b1)
        $display("FAIL spin_state k=%0d got=%0d en=%b exp=%0d en=1", k, bus.state, bus.motor_enable, exp_state);
      else n_pass++;
      if (k >= 90 && k < 105 && bus.motor_pwm === 1'b1) hi_cnt++;
    end
    n_checks++;
    if (hi_cnt != dm) $display("FAIL pwm_high_per_period got=%0d exp=%0d (dm=%0d)", hi_cnt, dm, dm);
    else n_pass++;
  endtask

  // From RUN at duty 10: hold freezes, then accelerate toward a lower limit
  // walks down one LSB every 4 cycles.
  task automatic test_hold_retarget(input int dm2);
    logic [3:0] p;
    int last_chg;
    bus.motor_ctrl_signal = 2'b11;
    step();
    step();
    bus.duty_max = 4'(dm2);
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (bus.duty !== 4'd10) $display("FAIL hold_duty i=%0d got=%0d exp=10", i, bus.duty);
      else n_pass++;
    end
    bus.motor_ctrl_signal = 2'b01;
    p = 4'd10;
    last_chg = -1;
    for (int i = 0; i < 4 * (10 - dm2) + 8; i++) begin
      step();
      if (bus.duty !== p) begin
        n_checks++;
        if (bus.duty !== p - 4'd1) $display("FAIL rampdown_step got=%0d exp=%0d", bus.duty, p - 4'd1);
        else n_pass++;
        if (last_chg >= 0) begin
          n_checks++;
          if (cyc - last_chg != 4) $display("FAIL rampdown_interval got=%0d exp=4", cyc - last_chg);
          else n_pass++;
        end
        last_chg = cyc;
        p = bus.duty;
      end
    end
    n_checks++;
    if (bus.duty !== 4'(dm2) || bus.state !== 2'd2)
      $display("FAIL rampdown_final got duty=%0d state=%0d exp duty=%0d state=2", bus.duty, bus.state, dm2);
    else n_pass++;
  endtask

  // Tach stops in RUN: FAULT exactly 100 cycles after the last strobe.
  task automatic test_watchdog();
    bit done;
    fb_period = 0;
    bus.feedback_clk = 1'b0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (cyc == last_pulse_cyc + 99) begin
        n_checks++;
        if (bus.state !== 2'd2) $display("FAIL wdog_early got state=%0d exp=2", bus.state);
        else n_pass++;
      end
      if (cyc == last_pulse_cyc + 100) begin
        done = 1;
        n_checks++;
        if (bus.state !== 2'd3 || bus.fault !== 1'b1 || bus.motor_enable !== 1'b0 ||
            bus.motor_brake !== 1'b1 || bus.duty !== 4'd0 || bus.motor_pwm !== 1'b0)
          $display("FAIL wdog_fault got state=%0d flt=%b en=%b brk=%b duty=%0d pwm=%b exp 3/1/0/1/0/0",
                   bus.state, bus.fault, bus.motor_enable, bus.motor_brake, bus.duty, bus.motor_pwm);
        else n_pass++;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wdog_bound got no expiry point exp fault within 200 cycles");
    end
    bus.motor_ctrl_signal = 2'b01;
    repeat (5) step();
    n_checks++;
    if (bus.state !== 2'd3 || bus.fault !== 1'b1) $display("FAIL fault_sticky got state=%0d flt=%b exp 3/1", bus.state, bus.fault);
    else n_pass++;
    bus.motor_ctrl_signal = 2'b00;
    step();
    step();
    n_checks++;
    if (bus.state !== 2'd0 || bus.fault !== 1'b0 || bus.motor_brake !== 1'b0)
      $display("FAIL fault_clear got state=%0d flt=%b brk=%b exp 0/0/0", bus.state, bus.fault, bus.motor_brake);
    else n_pass++;
  endtask

  task automatic test_brake();
    test_spinup(10, 40);
    bus.motor_ctrl_signal = 2'b10;
    step();
    n_checks++;
    if (bus.state !== 2'd2 || bus.duty !== 4'd10) $display("FAIL brake_latency got state=%0d duty=%0d exp 2/10", bus.state, bus.duty);
    else n_pass++;
    step();
    n_checks++;
    if (bus.state !== 2'd0 || bus.duty !== 4'd0 || bus.motor_brake !== 1'b1 ||
        bus.motor_pwm !== 1'b0 || bus.motor_enable !== 1'b0)
      $display("FAIL brake_apply got state=%0d duty=%0d brk=%b pwm=%b en=%b exp 0/0/1/0/0",
               bus.state, bus.duty, bus.motor_brake, bus.motor_pwm, bus.motor_enable);
    else n_pass++;
    bus.motor_ctrl_signal = 2'b11;
    repeat (3) step();
    n_checks++;
    if (bus.state !== 2'd0 || bus.motor_brake !== 1'b1) $display("FAIL brake_hold got state=%0d brk=%b exp 0/1", bus.state, bus.motor_brake);
    else n_pass++;
    bus.motor_ctrl_signal = 2'b00;
    step();
    step();
    n_checks++;
    if (bus.state !== 2'd0 || bus.motor_brake !== 1'b0) $display("FAIL brake_release got state=%0d brk=%b exp 0/0", bus.state, bus.motor_brake);
    else n_pass++;
  endtask

  // No tach at all: FAULT 100 cycles after SPINUP entry.
  task automatic test_spinup_timeout();
    do_reset();
    bus.duty_max = 4'($urandom_range(1, 15));
    bus.motor_ctrl_signal = 2'b01;
    step();
    step();
    n_checks++;
    if (bus.state !== 2'd1) $display("FAIL to_entry got state=%0d exp=1", bus.state);
    else n_pass++;
    repeat (99) step();
    n_checks++;
    if (bus.state !== 2'd1) $display("FAIL to_early got state=%0d exp=1", bus.state);
    else n_pass++;
    step();
    n_checks++;
    if (bus.state !== 2'd3 || bus.fault !== 1'b1 || bus.duty !== 4'd0)
      $display("FAIL to_fault got state=%0d flt=%b duty=%0d exp 3/1/0", bus.state, bus.fault, bus.duty);
    else n_pass++;
    bus.motor_ctrl_signal = 2'b00;
    step();
    step();
  endtask

  task automatic test_reset_midramp();
    int cnt;
    do_reset();
    bus.duty_max = 4'd10;
    bus.motor_ctrl_signal = 2'b01;
    step();
    step();
    repeat (21) step();
    n_checks++;
    if (bus.duty !== 4'd6) $display("FAIL midramp_duty got=%0d exp=6", bus.duty);
    else n_pass++;
    reset = 1'b1;
    bus.motor_ctrl_signal = 2'b00;
    step();
    n_checks++;
    if ({bus.state, bus.duty, bus.motor_pwm, bus.motor_enable, bus.motor_brake, bus.fault, bus.feedback_pulse} !== 11'b0)
      $display("FAIL midramp_reset got state=%0d duty=%0d pwm=%b en=%b brk=%b flt=%b exp all 0",
               bus.state, bus.duty, bus.motor_pwm, bus.motor_enable, bus.motor_brake, bus.fault);
    else n_pass++;
    step();
    reset = 1'b0;
    repeat (4) step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) bus.feedback_clk = 1'b1;
      if (i == 2) bus.feedback_clk = 1'b0;
      step();
      if (bus.feedback_pulse === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 1) $display("FAIL wide_tach_pulses got=%0d exp=1", cnt);
    else n_pass++;
  endtask

  initial begin
    bus.motor_ctrl_signal = 2'b00;
    bus.feedback_clk = 1'b0;
    bus.duty_max = 4'd0;
    test_reset();
    test_spinup(10, 40);
    test_hold_retarget($urandom_range(1, 9));
    test_watchdog();
    test_spinup($urandom_range(3, 14), $urandom_range(30, 60));
    test_spinup($urandom_range(3, 14), $urandom_range(30, 60));
    test_spinup(15, 50);
    test_brake();
    test_spinup_timeout();
    test_reset_midramp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got still running exp finished");
    $fatal(1, "time limit");
  end

endmodule
